// File: rtl/polyphase_decim2_fir.sv
// Decimate-by-2 polyphase FIR: even/odd sub-filters share one serial MAC, full-precision result.
// Latency 2*TAPS+1 cycles from capture; pairs arriving mid-MAC are dropped and flagged in sticky OVF.
module polyphase_decim2_fir #(
  parameter int BW   = 6,
  parameter int CW   = 6,
  parameter int TAPS = 4,
  parameter int AW   = BW + CW + $clog2(2*TAPS)
) (
  input  logic                        CLK,
  input  logic                        RES,
  input  logic                        IN_VALID,
  input  logic signed [BW-1:0]        IN1,
  input  logic signed [BW-1:0]        IN2,
  input  logic                        COEF_WE,
  input  logic [$clog2(2*TAPS)-1:0]   COEF_ADDR,
  input  logic signed [CW-1:0]        COEF_DATA,
  output logic signed [AW-1:0]        OUT,
  output logic                        OUT_VALID,
  output logic                        BUSY,
  output logic                        OVF
);

  localparam int IW = $clog2(2*TAPS);
  localparam int PW = BW + CW;

  typedef enum logic [1:0] {IDLE, MAC, DUMP} state_t;

  state_t                state_q;
  logic [IW-1:0]         idx_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  out_q;
  logic                  out_vld_q;
  logic                  ovf_q;
  logic signed [BW-1:0]  e_q [TAPS];
  logic signed [BW-1:0]  o_q [TAPS];
  logic signed [CW-1:0]  c_q [2*TAPS];

  logic                  capture;
  logic                  coef_wr;
  logic signed [BW-1:0]  samp_d;
  logic signed [CW-1:0]  coef_d;
  logic signed [PW-1:0]  prod_d;
  logic signed [AW-1:0]  prod_ext_d;

  // Coefficients and delay lines are frozen while the MAC is walking them.
  assign capture = IN_VALID && (state_q != MAC);
  assign coef_wr = COEF_WE && (state_q != MAC);

  always_comb begin
    samp_d = '0;
    coef_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx_q == IW'(k))        samp_d = e_q[k];
      if (idx_q == IW'(k + TAPS)) samp_d = o_q[k];
    end
    for (int k = 0; k < 2*TAPS; k++) begin
      if (idx_q == IW'(k)) coef_d = c_q[k];
    end
    prod_d     = PW'(samp_d) * PW'(coef_d);
    prod_ext_d = AW'(prod_d);
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        e_q[k] <= '0;
        o_q[k] <= '0;
      end
      for (int k = 0; k < 2*TAPS; k++) begin
        c_q[k] <= '0;
      end
    end else begin
      out_vld_q <= 1'b0;

      if (coef_wr) begin
        for (int k = 0; k < 2*TAPS; k++) begin
          if (COEF_ADDR == IW'(k)) c_q[k] <= COEF_DATA;
        end
      end

      if (capture) begin
        e_q[0] <= IN1;
        o_q[0] <= IN2;
        for (int k = 1; k < TAPS; k++) begin
          e_q[k] <= e_q[k-1];
          o_q[k] <= o_q[k-1];
        end
      end

      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod_ext_d;
          idx_q <= idx_q + IW'(1);
          if (IN_VALID) ovf_q <= 1'b1;
          if (idx_q == IW'(2*TAPS - 1)) state_q <= DUMP;
        end
        DUMP: begin
          out_q     <= acc_q;
          out_vld_q <= 1'b1;
          if (IN_VALID) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_vld_q;
  assign BUSY      = (state_q == MAC);
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_polyphase_decim2_fir.sv
// Directed bench for polyphase_decim2_fir with hand-computed expected results.
module tb_polyphase_decim2_fir;

  logic               CLK = 1'b0;
  logic               RES;
  logic               IN_VALID;
  logic signed [5:0]  IN1;
  logic signed [5:0]  IN2;
  logic               COEF_WE;
  logic [2:0]         COEF_ADDR;
  logic signed [5:0]  COEF_DATA;
  logic signed [14:0] OUT;
  logic               OUT_VALID;
  logic               BUSY;
  logic               OVF;

  int vectors     = 0;
  int miscompares = 0;

  polyphase_decim2_fir dut (
    .CLK       (CLK),
    .RES       (RES),
    .IN_VALID  (IN_VALID),
    .IN1       (IN1),
    .IN2       (IN2),
    .COEF_WE   (COEF_WE),
    .COEF_ADDR (COEF_ADDR),
    .COEF_DATA (COEF_DATA),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    RES = 1'b0;
    repeat (2) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic signed [5:0] data);
    COEF_WE = 1'b1; COEF_ADDR = addr; COEF_DATA = data;
    @(negedge CLK);
    COEF_WE = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where OUT_VALID is seen.
  task automatic send(input logic signed [5:0] a, input logic signed [5:0] b,
                      output logic signed [14:0] res, output int lat);
    IN_VALID = 1'b1; IN1 = a; IN2 = b;
    @(negedge CLK);
    IN_VALID = 1'b0; COEF_WE = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin lat = k; break; end
    end
    res = OUT;
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: no OUT_VALID within 30 cycles for pair (%0d,%0d)", a, b);
    end
  endtask

  task automatic test_reset();
    logic signed [14:0] res;
    int lat;
    RES = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (OUT !== 15'sd0)    begin miscompares++; $display("FAIL rst_out: got %0d want 0", OUT); end
    vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_vld: got %b want 0", OUT_VALID); end
    vectors++; if (BUSY !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    vectors++; if (OVF !== 1'b0)      begin miscompares++; $display("FAIL rst_ovf: got %b want 0", OVF); end
    RES = 1'b1;
    @(negedge CLK);
    send(6'sd5, -6'sd3, res, lat);
    vectors++; if (res !== 15'sd0) begin miscompares++; $display("FAIL zero_coef_out: got %0d want 0", res); end
    vectors++; if (lat != 9)       begin miscompares++; $display("FAIL zero_coef_latency: got %0d want 9", lat); end
    @(negedge CLK);
    vectors++; if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL vld_one_cycle: got %b want 0", OUT_VALID); end
  endtask

  task automatic test_phase_sum();
    logic signed [14:0] res;
    int lat;
    write_coef(3'd0, 6'sd1);
    write_coef(3'd4, 6'sd1);
    send(6'sd5, -6'sd3, res, lat);
    vectors++; if (res !== 15'sd2)  begin miscompares++; $display("FAIL phase_sum_1: got %0d want 2", res); end
    send(6'sd7, 6'sd7, res, lat);
    vectors++; if (res !== 15'sd14) begin miscompares++; $display("FAIL phase_sum_2: got %0d want 14", res); end
  endtask

  task automatic test_impulse();
    logic signed [14:0] res;
    logic signed [14:0] exp;
    int lat;
    int cv [8] = '{1, 2, 3, 4, -1, -2, -3, -4};
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(3'(i), 6'(cv[i]));
    for (int k = 0; k < 4; k++) begin
      send((k == 0) ? 6'sd1 : 6'sd0, 6'sd0, res, lat);
      exp = 15'(k + 1);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL impulse_even[%0d]: got %0d want %0d", k, res, exp); end
    end
    for (int k = 0; k < 4; k++) begin
      send(6'sd0, (k == 0) ? 6'sd1 : 6'sd0, res, lat);
      exp = 15'(-(k + 1));
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL impulse_odd[%0d]: got %0d want %0d", k, res, exp); end
    end
  endtask

  task automatic test_worst_case();
    logic signed [14:0] res;
    logic signed [14:0] exp;
    int lat;
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(3'(i), -6'sd32);
    for (int k = 0; k < 4; k++) begin
      send(-6'sd32, -6'sd32, res, lat);
      if (k == 0) begin
        vectors++; if (res !== 15'sd2048) begin miscompares++; $display("FAIL worst_first: got %0d want 2048", res); end
      end
    end
    exp = 15'sd8192;
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL worst_pos: got %0d want 8192", res); end
    for (int i = 0; i < 8; i++) write_coef(3'(i), 6'sd31);
    for (int k = 0; k < 4; k++) send(-6'sd32, -6'sd32, res, lat);
    exp = -15'sd7936;
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL worst_neg: got %0d want -7936", res); end
  endtask

  task automatic test_drop();
    logic signed [14:0] res;
    int lat;
    int cv [8] = '{1, 2, 3, 4, -1, -2, -3, -4};
    do_reset();
    for (int i = 0; i < 8; i++) write_coef(3'(i), 6'(cv[i]));
    send(6'sd3, 6'sd2, res, lat);
    vectors++; if (res !== 15'sd1) begin miscompares++; $display("FAIL drop_pre: got %0d want 1", res); end
    IN_VALID = 1'b1; IN1 = 6'sd5; IN2 = -6'sd4;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL drop_busy: got %b want 1", BUSY); end
    IN_VALID = 1'b1; IN1 = 6'sd9; IN2 = 6'sd9;
    @(negedge CLK);
    IN_VALID = 1'b0;
    lat = -1;
    for (int k = 4; k <= 30; k++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin lat = k; break; end
    end
    vectors++; if (lat != 9)        begin miscompares++; $display("FAIL drop_latency: got %0d want 9", lat); end
    vectors++; if (OUT !== 15'sd11) begin miscompares++; $display("FAIL drop_result: got %0d want 11", OUT); end
    vectors++; if (OVF !== 1'b1)    begin miscompares++; $display("FAIL drop_ovf: got %b want 1", OVF); end
    send(6'sd0, 6'sd0, res, lat);
    vectors++; if (res !== 15'sd21) begin miscompares++; $display("FAIL drop_delay_line: got %0d want 21", res); end
  endtask

  task automatic test_back_to_back();
    int lat;
    IN_VALID = 1'b1; IN1 = 6'sd1; IN2 = 6'sd1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    for (int k = 0; k < 20 && BUSY !== 1'b0; k++) @(negedge CLK);
    IN_VALID = 1'b1; IN1 = 6'sd2; IN2 = -6'sd1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    vectors++; if (OUT_VALID !== 1'b1) begin miscompares++; $display("FAIL b2b_first_vld: got %b want 1", OUT_VALID); end
    vectors++; if (OUT !== 15'sd31)    begin miscompares++; $display("FAIL b2b_first_out: got %0d want 31", OUT); end
    vectors++; if (BUSY !== 1'b1)      begin miscompares++; $display("FAIL b2b_accept: got busy %b want 1", BUSY); end
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin lat = k; break; end
    end
    vectors++; if (lat != 9)        begin miscompares++; $display("FAIL b2b_spacing: got %0d want 9", lat); end
    vectors++; if (OUT !== 15'sd39) begin miscompares++; $display("FAIL b2b_second_out: got %0d want 39", OUT); end
    @(negedge CLK);
  endtask

  task automatic test_coef_lock();
    logic signed [14:0] res;
    int lat;
    IN_VALID = 1'b1; IN1 = 6'sd1; IN2 = 6'sd0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    COEF_WE = 1'b1; COEF_ADDR = 3'd5; COEF_DATA = 6'sd10;
    @(negedge CLK);
    COEF_WE = 1'b0;
    lat = -1;
    for (int k = 2; k <= 30; k++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) begin lat = k; break; end
    end
    vectors++; if (lat != 9)       begin miscompares++; $display("FAIL lock_latency: got %0d want 9", lat); end
    vectors++; if (OUT !== 15'sd7) begin miscompares++; $display("FAIL coef_lock: got %0d want 7", OUT); end
    COEF_WE = 1'b1; COEF_ADDR = 3'd1; COEF_DATA = 6'sd5;
    send(6'sd0, 6'sd0, res, lat);
    vectors++; if (res !== 15'sd14) begin miscompares++; $display("FAIL coef_with_capture: got %0d want 14", res); end
  endtask

  task automatic test_reset_abort();
    logic signed [14:0] res;
    int lat;
    int seen;
    IN_VALID = 1'b1; IN1 = 6'sd1; IN2 = 6'sd1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy: got %b want 1", BUSY); end
    RES = 1'b0;
    #1;
    vectors++; if (BUSY !== 1'b0)      begin miscompares++; $display("FAIL abort_busy: got %b want 0", BUSY); end
    vectors++; if (OUT !== 15'sd0)     begin miscompares++; $display("FAIL abort_out: got %0d want 0", OUT); end
    vectors++; if (OVF !== 1'b0)       begin miscompares++; $display("FAIL abort_ovf: got %b want 0", OVF); end
    seen = 0;
    repeat (2) @(negedge CLK);
    RES = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL abort_no_vld: got %0d pulses want 0", seen); end
    send(6'sd5, 6'sd5, res, lat);
    vectors++; if (res !== 15'sd0) begin miscompares++; $display("FAIL abort_coef_clear: got %0d want 0", res); end
  endtask

  initial begin
    RES = 1'b0; IN_VALID = 1'b0; IN1 = '0; IN2 = '0;
    COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0;
    test_reset();
    test_phase_sum();
    test_impulse();
    test_worst_case();
    test_drop();
    test_back_to_back();
    test_coef_lock();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
